spi_ram_access_ctrl: RTL
========================

# spi_ram_access_ctrl

Sequencer and arbiter for the single-port RAM behind the SPI slave. Decodes the 10-bit command words delivered by the SPI slave (`rx_data`/`rx_valid`), keeps the write and read address registers, and turns data commands into RAM accesses. Shares the RAM round-robin with a local host port. Returns read bytes to the slave's `tx_data`/`tx_valid` inputs or to the host.

## Interface
- `MEM_DEPTH`, default 256: number of RAM words.
- `ADDR_SIZE`, default 8: RAM address width. Must satisfy `2**ADDR_SIZE >= MEM_DEPTH`.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `spi_rx_data` in 10: SPI command word. Bits [9:8] are the opcode; bits [7:0] are the payload.
- `spi_rx_valid` in 1: one-cycle strobe marking `spi_rx_data` valid.
- `spi_tx_data` out 8: read byte returned to the SPI slave.
- `spi_tx_valid` out 1: one-cycle strobe marking `spi_tx_data` valid.
- `spi_overrun` out 1: sticky flag, set when a data command is dropped. Cleared only by reset.
- `host_req` in 1: host access request. Held high until `host_gnt`.
- `host_we` in 1: 1 = write, 0 = read. Stable while `host_req` is high.
- `host_addr` in ADDR_SIZE: host address. Stable while `host_req` is high.
- `host_wdata` in 8: host write data. Stable while `host_req` is high.
- `host_gnt` out 1: one-cycle grant pulse.
- `host_rdata` out 8: host read data.
- `host_rvalid` out 1: one-cycle strobe marking `host_rdata` valid.
- `ram_en` out 1: RAM enable, registered.
- `ram_we` out 1: RAM write enable, registered.
- `ram_addr` out ADDR_SIZE: RAM address, registered.
- `ram_wdata` out 8: RAM write data, registered.
- `ram_rdata` in 8: RAM read data. Valid in the cycle after `ram_en` with `ram_we`=0.

## Operation
- **Opcodes:**
  - 00 WR_ADDR: `wr_addr <= payload`.
  - 01 WR_DATA: queue a RAM write of payload to `wr_addr`.
  - 10 RD_ADDR: `rd_addr <= payload`.
  - 11 RD_DATA: queue a RAM read at `rd_addr`. Payload is ignored.
- **Address latching:** WR_ADDR and RD_ADDR latch on the `spi_rx_valid` cycle, in any FSM state, without arbitration.
- **Payload width:** the payload is truncated to ADDR_SIZE when ADDR_SIZE < 8 and zero-extended when ADDR_SIZE > 8.
- **SPI pending buffer:** data commands go into a single-entry buffer (`spi_pend`, op, address, data).
  - A data command arriving while `spi_pend`=1 is dropped and sets `spi_overrun`.
  - The pending entry is unchanged by the dropped command.
  - A data command arriving in the same cycle `spi_pend` clears is accepted.
- **FSM states:**
  - IDLE: if any requester is pending, arbitrate → ACCESS. Otherwise stay in IDLE.
  - ACCESS: `ram_en`=1 for exactly this cycle. A write goes → IDLE. A read goes → RDWAIT.
  - RDWAIT: capture `ram_rdata` → IDLE.
- **Arbitration (round-robin, two requesters):**
  - If both SPI and host are pending in IDLE, the winner is the requester not served last.
  - A lone requester always wins.
  - `last` updates on every grant. Its reset value is HOST, so SPI wins the first tie.
- **Grant side effects:**
  - On entering ACCESS for the host, `host_gnt` pulses for 1 cycle, coincident with `ram_en`.
  - On entering ACCESS for SPI, `spi_pend` clears in the same cycle.
- **Read return:**
  - The captured byte drives `spi_tx_data`/`spi_tx_valid` or `host_rdata`/`host_rvalid`, according to the ACCESS owner.
  - The strobe lasts 1 cycle.
  - The data holds until the next read completes for that requester.
- **Writes:** no response strobe.
- **Reset:**
  - All outputs are 0; `spi_overrun`=0.
  - `wr_addr`=`rd_addr`=0, `spi_pend`=0, `last`=HOST, state IDLE.
- **Reset mid-operation:** an in-flight access is abandoned, no strobe is emitted, and the pending entry is lost.

## Timing
- Cycle 0 is the cycle a request is visible in IDLE: `spi_pend`=1 (earliest is the cycle after `spi_rx_valid`), or `host_req`=1.
- Write: `ram_en`/`ram_we` are high in cycle 1, and the FSM is back in IDLE in cycle 2.
  - Back-to-back accesses are therefore every 2 cycles.
- Read: `ram_en` is high in cycle 1 and `ram_rdata` is sampled at the end of cycle 2.
  - `*_tx_valid`/`host_rvalid` is high in cycle 3, while the FSM is in IDLE; a new access can start in cycle 4.
- Latency from `spi_rx_valid` to `spi_tx_valid` for RD_DATA, uncontended: 4 cycles.
- Worst-case SPI wait behind a host read is 3 extra cycles. This is far below one 10-bit SPI frame, so overrun only arises from a host-starved configuration or malformed stimulus.
- `host_req` may drop only after `host_gnt`. Deasserting it earlier is illegal and is not checked.

## Structure
- `spi_ram_pkg`:
  - opcode constants `CMD_WR_ADDR`/`CMD_WR_DATA`/`CMD_RD_ADDR`/`CMD_RD_DATA`;
  - FSM state enum (IDLE, ACCESS, RDWAIT);
  - requester enum (SPI, HOST).
- One sub-module, `rr_arb2`: two-request round-robin arbiter with a `last` register and an update-on-grant input. It is purely arbitration; the FSM stays in the top.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `spi_overrun`=0.
- **SPI write then read:**
  - Stimulus: SPI WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA.
  - Required: `ram_we`=1, `ram_addr`=0x3C, `ram_wdata`=0xA5; then `spi_tx_data`=0xA5 with `spi_tx_valid`, 4 cycles after the RD_DATA strobe.
- **Host write/read:** host write 0x10←0x5A, then read 0x10 → `host_gnt` pulses coincide with `ram_en`; `host_rdata`=0x5A with `host_rvalid` 3 cycles after the read's cycle 0.
- **Simultaneous requests:**
  - Stimulus: SPI RD_DATA pending and `host_req` held in the same IDLE cycle, right after reset.
  - Required: SPI is served first, host next; on a repeated tie the host wins if it was not served last.
- **Overrun:**
  - Stimulus: hold `host_req` continuously; send WR_DATA 0x11 and then WR_DATA 0x22 before the first is granted.
  - Required: `spi_overrun`=1; only 0x11 is written.
- **Reset mid-read:**
  - Stimulus: assert `rst` during RDWAIT of an SPI read.
  - Required: no `spi_tx_valid`; after release, `rd_addr`=0 and the state is IDLE.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-side RAM access controller.
package spi_ram_pkg;

    // Opcodes carried in bits [9:8] of an SPI command word
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_e;

    // The two RAM requesters
    typedef enum logic {
        SPI  = 1'b0,
        HOST = 1'b1
    } requester_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. The winner is combinational; the
// last-served register only moves when the caller takes the grant.
module rr_arb2
    import spi_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_req,
    input  logic       host_req,
    input  logic       grant_take,
    output logic       any_req,
    output requester_e winner
);

    requester_e last;

    // Lone requester wins; on a tie the one not served last wins
    always_comb begin
        any_req = spi_req | host_req;
        if (spi_req && host_req) begin
            winner = (last == HOST) ? SPI : HOST;
        end else if (host_req) begin
            winner = HOST;
        end else begin
            winner = SPI;
        end
    end

    // Remember who was served, starting from HOST so SPI wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= HOST;
        end else if (grant_take) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/spi_ram_access_ctrl.sv
// Decodes SPI command words, buffers one SPI data command, and shares the
// single-port RAM round-robin between SPI and a local host port.
module spi_ram_access_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           spi_rx_data,
    input  logic                 spi_rx_valid,
    output logic [7:0]           spi_tx_data,
    output logic                 spi_tx_valid,
    output logic                 spi_overrun,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic [7:0]           host_rdata,
    output logic                 host_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata
);

    // Payload bits that fit in an address; narrower addresses truncate
    localparam int PAYLOAD_W = (ADDR_SIZE < 8) ? ADDR_SIZE : 8;

    if (2 ** ADDR_SIZE < MEM_DEPTH) begin : g_bad_depth
        $error("ADDR_SIZE cannot address MEM_DEPTH words");
    end

    state_e               state, state_next;
    requester_e           owner, winner;
    logic                 any_req, grant, spi_grant;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic                 spi_pend, pend_we;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [7:0]           pend_wdata;
    logic [1:0]           cmd_op;
    logic [7:0]           cmd_payload;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic                 cmd_is_data;
    logic                 ram_we_next, host_gnt_next;
    logic [ADDR_SIZE-1:0] ram_addr_next;
    logic [7:0]           ram_wdata_next;

    assign cmd_op      = spi_rx_data[9:8];
    assign cmd_payload = spi_rx_data[7:0];
    assign cmd_addr    = ADDR_SIZE'(cmd_payload[PAYLOAD_W-1:0]);
    assign cmd_is_data = spi_rx_valid && (cmd_op == CMD_WR_DATA || cmd_op == CMD_RD_DATA);
    assign spi_grant   = grant && (winner == SPI);

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .spi_req    (spi_pend),
        .host_req   (host_req),
        .grant_take (grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    // Next state plus the values the RAM port registers take on a grant
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
        state_next     = state;
        grant          = 1'b0;
        ram_we_next    = 1'b0;
        ram_addr_next  = ram_addr;
        ram_wdata_next = ram_wdata;
        host_gnt_next  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                    if (winner == SPI) begin
                        ram_we_next    = pend_we;
                        ram_addr_next  = pend_addr;
                        ram_wdata_next = pend_wdata;
                    end else begin
                        ram_we_next    = host_we;
                        ram_addr_next  = host_addr;
                        ram_wdata_next = host_wdata;
                        host_gnt_next  = 1'b1;
                    end
                end
            end
            ACCESS:  state_next = ram_we ? IDLE : RDWAIT;
            RDWAIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sequencer state and access owner
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            owner <= HOST;
        end else begin
            state <= state_next;
            if (grant) begin
                owner <= winner;
            end
        end
    end

    // Registered RAM port and host grant pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            host_gnt  <= 1'b0;
        end else begin
            ram_en    <= grant;
            ram_we    <= ram_we_next;
            ram_addr  <= ram_addr_next;
            ram_wdata <= ram_wdata_next;
            host_gnt  <= host_gnt_next;
        end
    end

    // Address registers, single-entry SPI buffer and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            spi_pend    <= 1'b0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
            pend_wdata  <= '0;
            spi_overrun <= 1'b0;
        end else begin
            if (spi_rx_valid && cmd_op == CMD_WR_ADDR) begin
                wr_addr <= cmd_addr;
            end
            if (spi_rx_valid && cmd_op == CMD_RD_ADDR) begin
                rd_addr <= cmd_addr;
            end
            if (cmd_is_data) begin
                // The slot frees in the same cycle it is granted, so accept then too
                if (!spi_pend || spi_grant) begin
                    spi_pend   <= 1'b1;
                    pend_we    <= (cmd_op == CMD_WR_DATA);
                    pend_addr  <= (cmd_op == CMD_WR_DATA) ? wr_addr : rd_addr;
                    pend_wdata <= cmd_payload;
                end else begin
                    spi_overrun <= 1'b1;
                end
            end else if (spi_grant) begin
                spi_pend <= 1'b0;
            end
        end
    end

    // Capture read data in RDWAIT and return it to whoever owned the access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
        end else begin
            spi_tx_valid <= 1'b0;
            host_rvalid  <= 1'b0;
            if (state == RDWAIT) begin
                if (owner == SPI) begin
                    spi_tx_data  <= ram_rdata;
                    spi_tx_valid <= 1'b1;
                end else begin
                    host_rdata  <= ram_rdata;
                    host_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule
